// File: rtl/grey_decode_int_pkg.sv
// Shared definitions for the Rx Gray symbol decoder: symbol width, the Gray map
// used by the Tx encoder, and the serializer state type.
package grey_pkg;

  localparam int SYM_W = 2;

  // Gray code transmitted for each binary bit pair (must match the Tx encoder)
  localparam logic [SYM_W-1:0] GRAY_B00 = 2'b00;
  localparam logic [SYM_W-1:0] GRAY_B01 = 2'b01;
  localparam logic [SYM_W-1:0] GRAY_B10 = 2'b11;
  localparam logic [SYM_W-1:0] GRAY_B11 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MSB,
    S_LSB
  } ser_state_t;

  function automatic logic [SYM_W-1:0] gray_decode(input logic [SYM_W-1:0] gray);
    logic [SYM_W-1:0] pair;
    pair = 2'b00;
    case (gray)
      GRAY_B00: pair = 2'b00;
      GRAY_B01: pair = 2'b01;
      GRAY_B10: pair = 2'b10;
      GRAY_B11: pair = 2'b11;
      default:  pair = 2'b00;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/grey_decode_int_if.sv
// Symbol input and serialized bit output streams of the Rx Gray decoder.
// The slave modport is the decoder side; master is the source/sink side.
interface grey_decode_int_if;
  import grey_pkg::*;

  logic [SYM_W-1:0] symbol_in;
  logic             symbol_in_valid;
  logic             symbol_in_ready;
  logic             data_out;
  logic             data_out_valid;
  logic             data_out_ready;

  modport master (
    output symbol_in,
    output symbol_in_valid,
    input  symbol_in_ready,
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );

  modport slave (
    input  symbol_in,
    input  symbol_in_valid,
    output symbol_in_ready,
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

endinterface

// File: rtl/grey_decode_int_sym_fifo.sv
// Single-clock FIFO with read data presented from the head entry.
// Pointers carry one extra bit so full and empty are distinguishable.
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/grey_decode_int.sv
// Rx Gray decoder: maps PAM4 Gray symbols to bit pairs, buffers them and
// serializes each pair MSB-first; symbols arriving while full are dropped and counted.
module grey_decode_int
  import grey_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  grey_decode_int_if.slave bus,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [SYM_W-1:0] wr_pair;
  logic [SYM_W-1:0] rd_pair;

  ser_state_t state;
  logic       lsb_hold;
  logic       out_bit;
  logic       out_valid;

  // Acceptance looks at full only; a same-cycle pop never frees a slot
  assign bus.symbol_in_ready = !full;
  assign push                = bus.symbol_in_valid && !full;
  assign wr_pair             = gray_decode(bus.symbol_in);

  assign pop = !empty && ((state == S_IDLE) ||
                          (state == S_LSB && bus.data_out_ready));

  assign bus.data_out       = out_bit;
  assign bus.data_out_valid = out_valid;

  sym_fifo #(
    .WIDTH(SYM_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (rd_pair),
    .full    (full),
    .empty   (empty)
  );

  // Serializer: loading straight from LSB keeps back-to-back pairs bubble-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lsb_hold  <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state     <= S_MSB;
            out_bit   <= rd_pair[1];
            lsb_hold  <= rd_pair[0];
            out_valid <= 1'b1;
          end
        end
        S_MSB: begin
          if (bus.data_out_ready) begin
            state   <= S_LSB;
            out_bit <= lsb_hold;
          end
        end
        S_LSB: begin
          if (bus.data_out_ready) begin
            if (!empty) begin
              state    <= S_MSB;
              out_bit  <= rd_pair[1];
              lsb_hold <= rd_pair[0];
            end else begin
              state     <= S_IDLE;
              out_bit   <= 1'b0;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (bus.symbol_in_valid && full) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grey_decode_int.sv
// Self-checking bench for grey_decode_int: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the decoder's behaviour.
module tb_grey_decode_int;
  import grey_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        overflow;
  logic [15:0] drop_count;
  logic        overflow2;
  logic [1:0]  drop_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grey_decode_int_if bus ();
  grey_decode_int_if bus2 ();

  // Second instance with a 2-bit counter sees identical input traffic
  assign bus2.symbol_in       = bus.symbol_in;
  assign bus2.symbol_in_valid = bus.symbol_in_valid;
  assign bus2.data_out_ready  = bus.data_out_ready;

  grey_decode_int #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  grey_decode_int #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .overflow   (overflow2),
    .drop_count (drop_count2)
  );

  logic [1:0] decode_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] m_fifo[$];
  bit         m_cur[$];
  bit         m_ovf;
  int         m_drops;
  int         m_drops2;
  bit         got_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] v;
    v = '0;
    foreach (got_bits[i]) v = {v[30:0], got_bits[i]};
    return v;
  endfunction

  task automatic check_outputs();
    check("ready",       32'(bus.symbol_in_ready),  32'(m_fifo.size() < DEPTH));
    check("valid",       32'(bus.data_out_valid),   32'(m_cur.size() > 0));
    if (m_cur.size() > 0) check("data", 32'(bus.data_out), 32'(m_cur[0]));
    check("overflow",    32'(overflow),             32'(m_ovf));
    check("drop_count",  32'(drop_count),           32'(m_drops));
    check("ready2",      32'(bus2.symbol_in_ready), 32'(m_fifo.size() < DEPTH));
    check("valid2",      32'(bus2.data_out_valid),  32'(m_cur.size() > 0));
    if (m_cur.size() > 0) check("data2", 32'(bus2.data_out), 32'(m_cur[0]));
    check("overflow2",   32'(overflow2),            32'(m_ovf));
    check("drop_count2", 32'(drop_count2),          32'(m_drops2));
  endtask

  // Behaviour at one clock edge, evaluated on the state seen before the edge
  task automatic model_edge(input bit v, input logic [1:0] s, input bit r);
    bit         accept;
    logic [1:0] p;
    accept = v && (m_fifo.size() < DEPTH);
    if (m_cur.size() > 0 && r) void'(m_cur.pop_front());
    if (m_cur.size() == 0 && m_fifo.size() > 0) begin
      p = m_fifo.pop_front();
      m_cur.push_back(p[1]);
      m_cur.push_back(p[0]);
    end
    if (accept) begin
      m_fifo.push_back(decode_tab[s]);
    end else if (v) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
      if (m_drops2 < 3) m_drops2++;
    end
  endtask

  task automatic apply_stimulus(input bit v, input logic [1:0] s, input bit r);
    check_outputs();
    if (bus.data_out_valid && r) got_bits.push_back(bus.data_out);
    bus.symbol_in_valid = v;
    bus.symbol_in       = s;
    bus.data_out_ready  = r;
    @(posedge clk);
    model_edge(v, s, r);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.symbol_in_valid = 1'b0;
    bus.data_out_ready  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid",    32'(bus.data_out_valid),  32'd0);
    check("rst_data",     32'(bus.data_out),        32'd0);
    check("rst_ready",    32'(bus.symbol_in_ready), 32'd1);
    check("rst_overflow", 32'(overflow),            32'd0);
    check("rst_drops",    32'(drop_count),          32'd0);
    check("rst_drops2",   32'(drop_count2),         32'd0);
    m_fifo.delete();
    m_cur.delete();
    got_bits.delete();
    m_ovf    = 1'b0;
    m_drops  = 0;
    m_drops2 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] codes [4];
    codes = '{2'b00, 2'b01, 2'b11, 2'b10};
    bus.symbol_in       = 2'b00;
    bus.symbol_in_valid = 1'b0;
    bus.data_out_ready  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    apply_reset();

    // Basic decode: 11,10 -> 1,0,1,1
    got_bits.delete();
    apply_stimulus(1'b1, 2'b11, 1'b1);
    apply_stimulus(1'b1, 2'b10, 1'b1);
    repeat (6) apply_stimulus(1'b0, 2'b00, 1'b1);
    check("basic_len",    32'(got_bits.size()), 32'd4);
    check("basic_stream", pack_bits(),          32'b1011);

    // All four codes back to back
    got_bits.delete();
    foreach (codes[i]) apply_stimulus(1'b1, codes[i], 1'b1);
    repeat (10) apply_stimulus(1'b0, 2'b00, 1'b1);
    check("codes_len",    32'(got_bits.size()), 32'd8);
    check("codes_stream", pack_bits(),          32'b00011011);

    // Backpressure with the MSB presented
    apply_stimulus(1'b1, 2'b01, 1'b1);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    repeat (3) apply_stimulus(1'b0, 2'b00, 1'b0);
    repeat (4) apply_stimulus(1'b0, 2'b00, 1'b1);

    // Overflow: six pushes while stalled, five fit
    repeat (6) apply_stimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_drops", 32'(drop_count), 32'd1);
    got_bits.delete();
    repeat (14) apply_stimulus(1'b0, 2'b00, 1'b1);
    check("ovf_drain_len", 32'(got_bits.size()), 32'd10);

    // Saturation of the 2-bit counter
    repeat (10) apply_stimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    check("sat_drops",  32'(drop_count),  32'd6);
    check("sat_drops2", 32'(drop_count2), 32'd3);
    apply_reset();

    // Reset while in LSB with two pairs queued
    apply_stimulus(1'b1, 2'b11, 1'b0);
    apply_stimulus(1'b1, 2'b01, 1'b0);
    apply_stimulus(1'b1, 2'b10, 1'b0);
    apply_stimulus(1'b0, 2'b00, 1'b1);
    apply_reset();
    repeat (6) apply_stimulus(1'b0, 2'b00, 1'b1);
    check("post_rst_bits", 32'(got_bits.size()), 32'd0);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      else apply_stimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) != 0));
    end
    repeat (14) apply_stimulus(1'b0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
